spi_slave_param: RTL and testbench

//  Parametrised SPI slave front end for the SPI wrapper; successor to the fixed 8-bit slave.
//  It deserialises MOSI frames of DATA_W+2 bits (2-bit opcode + payload) into rx_data, and

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_shreg.sv | 60 ++++++
 rtl/spi_slave_param.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the parametrised SPI slave.
//   spi_state_e  - control FSM states
//   OP_*         - 2-bit frame opcodes
//   op_is_read   - helper: opcode belongs to the read path
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        SHIFT_IN  = 3'd2,
        WAIT_TX   = 3'd3,
        SHIFT_OUT = 3'd4,
        HOLD      = 3'd5
    } spi_state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // The rw bit sent ahead of a frame must equal opcode[1].
    function automatic logic op_is_read(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/spi_shreg.sv
// spi_shreg: loadable MSB-first shift register with a saturating down-counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_i        load load_data_i and set the counter to W
//   load_data_i   parallel load value
//   shift_i       shift sin_i in at the LSB, decrement the counter
//   sin_i         serial input
//   data_o        current register contents
//   next_o        register contents as they will be after a shift this cycle
//   last_o        the shift in this cycle is the W-th one since the load
// W must be at least 2.
module spi_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] data_o,
    output logic [W-1:0] next_o,
    output logic         last_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign next_o = {data_q[W-2:0], sin_i};
    assign data_o = data_q;
    assign last_o = (cnt_q == CW'(1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = CW'(W);
        end else if (shift_i) begin
            data_d = next_o;
            // Saturate at zero so a stray shift never wraps the count.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front end with a DATA_W-bit payload.
// A frame is an rw bit followed by FRAME_W = DATA_W+2 bits {opcode, payload}, MSB first.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   SS_n        slave select, active low; raising it mid-transfer aborts
//   MOSI        serial in
//   MISO        serial out, read data MSB first, 0 otherwise
//   rx_data     last accepted frame {opcode, payload}
//   rx_valid    1-cycle pulse when rx_data is updated
//   tx_data     read data word
//   tx_valid    read data valid
//   frame_err   1-cycle pulse on abort, rw/opcode mismatch, read-data without
//               a prior read-address, or tx_valid timeout
//   state_o     current FSM state
//
// Read data handshake: tx_valid/tx_data are looked at only while the FSM is
// in WAIT_TX. The word is taken on the first edge there with tx_valid=1;
// there is no ready back to the source, and tx_valid outside WAIT_TX has no
// effect. If TX_TIMEOUT edges pass without tx_valid the request fails.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                frame_err,
    output spi_state_e          state_o
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int TW      = $clog2(TX_TIMEOUT + 1);

    spi_state_e         state_q;
    logic               rw_q;
    logic               rd_addr_seen_q;
    logic [TW-1:0]      timer_q;
    logic               miso_q;
    logic               rx_valid_q;
    logic               frame_err_q;
    logic [FRAME_W-1:0] rx_data_q;

    logic               rx_load, rx_shift, rx_last;
    logic [FRAME_W-1:0] rx_next;
    logic [FRAME_W-1:0] rx_cur;
    logic               tx_load, tx_shift, tx_last;
    logic [DATA_W-1:0]  tx_next;
    logic [DATA_W-1:0]  tx_cur;
    logic [1:0]         rx_op;

    // Only the bit about to be driven matters from the TX shifter, and the
    // RX shifter is consumed through next_o at the last bit.
    logic unused_shreg_bits;
    assign unused_shreg_bits = ^{tx_next[DATA_W-2:0], tx_cur, rx_cur};

    assign rx_load  = (state_q == CHK_CMD)   && !SS_n;
    assign rx_shift = (state_q == SHIFT_IN)  && !SS_n;
    assign tx_load  = (state_q == WAIT_TX)   && !SS_n && tx_valid;
    assign tx_shift = (state_q == SHIFT_OUT) && !SS_n;

    // rx_next already holds the complete frame on the edge of its last bit.
    assign rx_op = rx_next[FRAME_W-1 -: 2];

    spi_shreg #(.W(FRAME_W)) u_rx_shreg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (rx_load),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .sin_i       (MOSI),
        .data_o      (rx_cur),
        .next_o      (rx_next),
        .last_o      (rx_last)
    );

    spi_shreg #(.W(DATA_W)) u_tx_shreg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tx_load),
        .load_data_i (tx_data),
        .shift_i     (tx_shift),
        .sin_i       (1'b0),
        .data_o      (tx_cur),
        .next_o      (tx_next),
        .last_o      (tx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rw_q           <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            timer_q        <= '0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            rx_data_q      <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != IDLE && SS_n) begin
                // Deselect beats anything else happening in this cycle.
                state_q <= IDLE;
                miso_q  <= 1'b0;
                if (state_q != HOLD) begin
                    frame_err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!SS_n) begin
                            state_q <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        rw_q    <= MOSI;
                        state_q <= SHIFT_IN;
                    end
                    SHIFT_IN: begin
                        if (rx_last) begin
                            if ((rw_q != op_is_read(rx_op)) ||
                                (rx_op == OP_RD_DATA && !rd_addr_seen_q)) begin
                                frame_err_q <= 1'b1;
                                state_q     <= HOLD;
                            end else begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= rx_next;
                                if (rx_op == OP_RD_ADDR) begin
                                    rd_addr_seen_q <= 1'b1;
                                end
                                if (rx_op == OP_RD_DATA) begin
                                    timer_q <= TW'(TX_TIMEOUT);
                                    state_q <= WAIT_TX;
                                end else begin
                                    state_q <= HOLD;
                                end
                            end
                        end
                    end
                    WAIT_TX: begin
                        // tx_valid is checked first so data arriving on the
                        // final timer cycle is still accepted.
                        if (tx_valid) begin
                            miso_q  <= tx_data[DATA_W-1];
                            state_q <= SHIFT_OUT;
                        end else if (timer_q <= TW'(1)) begin
                            frame_err_q <= 1'b1;
                            miso_q      <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    SHIFT_OUT: begin
                        if (tx_last) begin
                            miso_q         <= 1'b0;
                            rd_addr_seen_q <= 1'b0;
                            state_q        <= HOLD;
                        end else begin
                            miso_q <= tx_next[DATA_W-1];
                        end
                    end
                    HOLD: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MISO      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16).
// Each transaction is described by its frame and by the edges at which
// SS_n rises, tx_valid arrives or rst fires; the expected per-edge outputs
// are derived from the frame timeline (SS_n low seen at edge 0, rw at
// edge 1, frame bits at edges 2..FW+1) rather than from any state machine.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int DW = 8;
    localparam int FW = DW + 2;
    localparam int TO = 16;
    localparam int NE = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          frame_err;
    spi_state_e    state;

    int            n_checks = 0;
    int            n_fail   = 0;
    string         tag;

    // Reference state carried between transactions.
    logic [FW-1:0] m_rxd;
    bit            m_seen;

    typedef struct {
        logic          rw;
        logic [FW-1:0] frame;
        int            ss_hi;
        int            tx_delay;
        logic [DW-1:0] txd;
        int            rst_edge;
        int            exp_rv_edge;
        int            exp_fe_edge;
        logic [FW-1:0] exp_rxd;
    } vec_t;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .MISO      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err),
        .state_o   (state)
    );

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s edge %0d: got 0x%0h expected 0x%0h", tag, name, e, act, exp);
        end
    endtask

    // ss_hi_in: edge where SS_n=1 is first sampled; -1 = shortly after the
    // transfer completes, -2 = random abort point inside the transfer.
    // tx_delay: edges after entering WAIT_TX at which tx_valid is seen (1..TO),
    // anything else = never. rst_edge: edge where rst is sampled high, -1 = none.
    task automatic do_txn(input logic rw, input logic [FW-1:0] frame, input int ss_hi_in,
                          input int tx_delay, input logic [DW-1:0] txd, input int rst_edge,
                          output int rv_edge, output int fe_edge);
        bit            exp_rv [NE];
        bit            exp_fe [NE];
        bit            exp_mo [NE];
        logic [FW-1:0] exp_rxd [NE];
        logic [1:0]    op;
        bit            ok, is_rd, abort, seen_next;
        int            active_end, acc, wait_end, ss_hi, cut, last;
        logic [FW-1:0] rxd_next;

        for (int e = 0; e < NE; e++) begin
            exp_rv[e] = 0;
            exp_fe[e] = 0;
            exp_mo[e] = 0;
        end
        op         = frame[FW-1 -: 2];
        ok         = (rw == op[1]) && !(op == OP_RD_DATA && !m_seen);
        is_rd      = ok && (op == OP_RD_DATA);
        active_end = FW + 1;
        acc        = -1;
        wait_end   = FW + 1 + TO;
        if (ok) exp_rv[FW+1] = 1;
        else    exp_fe[FW+1] = 1;
        if (is_rd) begin
            if (tx_delay >= 1 && tx_delay <= TO) begin
                acc = FW + 1 + tx_delay;
                wait_end = acc;
                for (int i = 0; i < DW; i++) exp_mo[acc+i] = txd[DW-1-i];
                active_end = acc + DW;
            end else begin
                exp_fe[FW+1+TO] = 1;
                active_end = FW + 1 + TO;
            end
        end

        if (ss_hi_in == -1)      ss_hi = active_end + 1 + int'($urandom_range(0, 2));
        else if (ss_hi_in == -2) ss_hi = int'($urandom_range(1, active_end));
        else                     ss_hi = ss_hi_in;

        if (rst_edge >= 0) begin
            cut   = rst_edge;
            ss_hi = rst_edge + 1;
            abort = 0;
        end else begin
            abort = (ss_hi <= active_end);
            cut   = abort ? ss_hi : NE;
        end
        for (int e = cut; e < NE; e++) begin
            exp_rv[e] = 0;
            exp_fe[e] = 0;
            exp_mo[e] = 0;
        end
        if (abort) exp_fe[ss_hi] = 1;

        rxd_next  = m_rxd;
        seen_next = m_seen;
        for (int e = 0; e < NE; e++) begin
            if (exp_rv[e]) begin
                rxd_next = frame;
                if (op == OP_RD_ADDR) seen_next = 1;
            end
            if (rst_edge >= 0 && e >= rst_edge) rxd_next = '0;
            exp_rxd[e] = rxd_next;
        end
        if (is_rd && acc >= 0 && active_end < cut) seen_next = 0;
        if (rst_edge >= 0) seen_next = 0;

        last    = ((ss_hi > active_end) ? ss_hi : active_end) + 1;
        rv_edge = -1;
        fe_edge = -1;
        for (int e = 0; e <= last; e++) begin
            ss_n = (e < ss_hi) ? 1'b0 : 1'b1;
            rst  = (e == rst_edge);
            if (e == 1)                  mosi = rw;
            else if (e >= 2 && e <= FW+1) mosi = frame[FW+1-e];
            else                         mosi = 1'($urandom_range(0, 1));
            if (is_rd && e >= FW + 2 && e <= wait_end) begin
                tx_valid = (e == acc);
                tx_data  = (e == acc) ? txd : DW'($urandom_range(0, 255));
            end else begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = DW'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
            chk("rx_valid",  e, 32'(rx_valid),  32'(exp_rv[e]));
            chk("frame_err", e, 32'(frame_err), 32'(exp_fe[e]));
            chk("miso",      e, 32'(miso),      32'(exp_mo[e]));
            chk("rx_data",   e, 32'(rx_data),   32'(exp_rxd[e]));
            if (rx_valid === 1'b1 && rv_edge < 0)  rv_edge = e;
            if (frame_err === 1'b1 && fe_edge < 0) fe_edge = e;
        end
        rst = 1'b0;
        chk("state_idle", last, 32'(state), 32'(IDLE));
        m_rxd  = rxd_next;
        m_seen = seen_next;
    endtask

    initial begin
        vec_t          vecs [17];
        int            rv_e, fe_e;
        logic [1:0]    op;
        logic          rw;
        int            ss_mode, txd_delay;

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        tag = "reset";
        chk("miso",      0, 32'(miso),      32'd0);
        chk("rx_valid",  0, 32'(rx_valid),  32'd0);
        chk("frame_err", 0, 32'(frame_err), 32'd0);
        chk("rx_data",   0, 32'(rx_data),   32'd0);
        chk("state",     0, 32'(state),     32'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_rxd  = '0;
        m_seen = 0;

        //          rw    frame     ss_hi txd  txdata rst  rv   fe   rx_data
        vecs[0]  = '{1'b0, 10'h0A5, 14,  0,  8'h00, -1,  11,  -1, 10'h0A5}; // write addr
        vecs[1]  = '{1'b1, 10'h300, 14,  0,  8'h00, -1,  -1,  11, 10'h0A5}; // rd data, no rd addr
        vecs[2]  = '{1'b1, 10'h155, 14,  0,  8'h00, -1,  -1,  11, 10'h0A5}; // rw mismatch
        vecs[3]  = '{1'b1, 10'h203, 14,  0,  8'h00, -1,  11,  -1, 10'h203}; // rd addr
        vecs[4]  = '{1'b1, 10'h35A, 24,  3,  8'hC3, -1,  11,  -1, 10'h35A}; // rd data, 0xC3 out
        vecs[5]  = '{1'b1, 10'h3FF, 14,  0,  8'h00, -1,  -1,  11, 10'h35A}; // rd_addr_seen cleared
        vecs[6]  = '{1'b1, 10'h2F0, 14,  0,  8'h00, -1,  11,  -1, 10'h2F0}; // rd addr
        vecs[7]  = '{1'b0, 10'h0FF,  7,  0,  8'h00, -1,  -1,   7, 10'h2F0}; // abort after 5 bits
        vecs[8]  = '{1'b0, 10'h011, 11,  0,  8'h00, -1,  -1,  11, 10'h2F0}; // abort on last bit
        vecs[9]  = '{1'b0, 10'h0AA,  1,  0,  8'h00, -1,  -1,   1, 10'h2F0}; // abort in rw cycle
        vecs[10] = '{1'b1, 10'h3AB, 30, -1,  8'h00, -1,  11,  27, 10'h3AB}; // tx timeout
        vecs[11] = '{1'b1, 10'h300, 37, 16,  8'h5A, -1,  11,  -1, 10'h300}; // tx_valid on last timer cycle
        vecs[12] = '{1'b1, 10'h2AA, 14,  0,  8'h00, -1,  11,  -1, 10'h2AA}; // rd addr
        vecs[13] = '{1'b1, 10'h3C0, 16,  1,  8'hFF, -1,  11,  16, 10'h3C0}; // abort mid shift-out
        vecs[14] = '{1'b0, 10'h1C7, 12,  0,  8'h00, -1,  11,  -1, 10'h1C7}; // write data
        vecs[15] = '{1'b1, 10'h3E1, -1,  2,  8'hA5, 16,  11,  -1, 10'h000}; // rst mid shift-out
        vecs[16] = '{1'b0, 10'h033, 14,  0,  8'h00, -1,  11,  -1, 10'h033}; // write after rst

        for (int i = 0; i < 17; i++) begin
            tag = $sformatf("vec%0d", i);
            do_txn(vecs[i].rw, vecs[i].frame, vecs[i].ss_hi, vecs[i].tx_delay,
                   vecs[i].txd, vecs[i].rst_edge, rv_e, fe_e);
            chk("rv_edge",   i, 32'(rv_e),    32'(vecs[i].exp_rv_edge));
            chk("fe_edge",   i, 32'(fe_e),    32'(vecs[i].exp_fe_edge));
            chk("final_rxd", i, 32'(rx_data), 32'(vecs[i].exp_rxd));
        end

        for (int i = 0; i < 60; i++) begin
            tag       = $sformatf("rnd%0d", i);
            op        = 2'($urandom_range(0, 3));
            rw        = ($urandom_range(0, 7) == 0) ? ~op[1] : op[1];
            ss_mode   = ($urandom_range(0, 9) < 3) ? -2 : -1;
            txd_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TO));
            do_txn(rw, {op, DW'($urandom_range(0, 255))}, ss_mode, txd_delay,
                   DW'($urandom_range(0, 255)), -1, rv_e, fe_e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
